// File: rtl/video_instruction_sequencer_if.sv
// Custom-instruction, decoder and register-bank signals of the video instruction sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding system.
interface video_instruction_sequencer_if #(
   parameter int PTR_W = 2
);
   logic             start;
   logic [31:0]      dataA;
   logic [31:0]      dataB;
   logic             done;
   logic [31:0]      result;
   logic [31:0]      dec_dataA;
   logic [31:0]      dec_dataB;
   logic             dec_clk_en;
   logic             new_instruction;
   logic [1:0]       opcode;
   logic [4:0]       R1;
   logic [27:0]      data;
   logic             bank_ready;
   logic             reg_wr;
   logic [1:0]       reg_sel;
   logic [4:0]       reg_addr;
   logic [27:0]      reg_data;
   logic [PTR_W:0]   fifo_count;

   modport slave (
      input  start, dataA, dataB, opcode, R1, data, bank_ready,
      output done, result, dec_dataA, dec_dataB, dec_clk_en, new_instruction,
             reg_wr, reg_sel, reg_addr, reg_data, fifo_count
   );

   modport master (
      output start, dataA, dataB, opcode, R1, data, bank_ready,
      input  done, result, dec_dataA, dec_dataB, dec_clk_en, new_instruction,
             reg_wr, reg_sel, reg_addr, reg_data, fifo_count
   );
endinterface

// File: rtl/video_instruction_sequencer.sv
// Buffers custom instructions in a FIFO, feeds them one at a time to the decoder
// and commits decoded results to the register bank.
//
// state   | meaning
// IDLE    | waiting for a queued instruction
// LOAD    | FIFO head presented on dec_dataA/dec_dataB
// STROBE  | dec_clk_en pulse, head held
// CAPTURE | pop head, latch decoder outputs (opcode 11 discarded)
// WRITE   | reg_wr held until bank_ready
module video_instruction_sequencer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   video_instruction_sequencer_if.slave  bus
);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STROBE,
      ST_CAPTURE,
      ST_WRITE
   } state_t;

   state_t           state_q, state_d;
   logic [63:0]      mem_q [DEPTH];
   logic [63:0]      mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             done_q, done_d;
   logic [31:0]      result_q, result_d;
   logic [31:0]      dec_dataA_q, dec_dataA_d;
   logic [31:0]      dec_dataB_q, dec_dataB_d;
   logic             dec_clk_en_q, dec_clk_en_d;
   logic             new_instruction_q, new_instruction_d;
   logic             reg_wr_q, reg_wr_d;
   logic [1:0]       reg_sel_q, reg_sel_d;
   logic [4:0]       reg_addr_q, reg_addr_d;
   logic [27:0]      reg_data_q, reg_data_d;

   logic             full;
   logic             push;
   logic             pop;
   logic [63:0]      head;

   always_comb begin
      full = (count_q == FULL_CNT);
      // fullness is judged on the registered count, so a same-cycle pop cannot rescue a push
      push = bus.start && !full;
      pop  = (state_q == ST_CAPTURE);
      head = mem_q[rd_ptr_q];

      mem_d             = mem_q;
      wr_ptr_d          = wr_ptr_q;
      rd_ptr_d          = rd_ptr_q;
      count_d           = count_q;
      state_d           = state_q;
      dec_dataA_d       = dec_dataA_q;
      dec_dataB_d       = dec_dataB_q;
      dec_clk_en_d      = 1'b0;
      new_instruction_d = 1'b1;
      reg_wr_d          = reg_wr_q;
      reg_sel_d         = reg_sel_q;
      reg_addr_d        = reg_addr_q;
      reg_data_d        = reg_data_q;

      done_d   = bus.start;
      result_d = {31'b0, bus.start & full};

      if (push) begin
         mem_d[wr_ptr_q] = {bus.dataA, bus.dataB};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               state_d           = ST_LOAD;
               dec_dataA_d       = head[63:32];
               dec_dataB_d       = head[31:0];
               new_instruction_d = 1'b0;
            end
         end
         ST_LOAD: begin
            state_d           = ST_STROBE;
            dec_clk_en_d      = 1'b1;
            new_instruction_d = 1'b0;
         end
         ST_STROBE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (bus.opcode == 2'b11) begin
               state_d = ST_IDLE;
            end else begin
               state_d    = ST_WRITE;
               reg_wr_d   = 1'b1;
               reg_sel_d  = bus.opcode;
               reg_addr_d = bus.R1;
               reg_data_d = bus.data;
            end
         end
         ST_WRITE: begin
            if (reg_wr_q && bus.bank_ready) begin
               state_d  = ST_IDLE;
               reg_wr_d = 1'b0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            reg_wr_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         count_q           <= '0;
         state_q           <= ST_IDLE;
         done_q            <= 1'b0;
         result_q          <= '0;
         dec_dataA_q       <= '0;
         dec_dataB_q       <= '0;
         dec_clk_en_q      <= 1'b0;
         new_instruction_q <= 1'b1;
         reg_wr_q          <= 1'b0;
         reg_sel_q         <= '0;
         reg_addr_q        <= '0;
         reg_data_q        <= '0;
      end else begin
         mem_q             <= mem_d;
         wr_ptr_q          <= wr_ptr_d;
         rd_ptr_q          <= rd_ptr_d;
         count_q           <= count_d;
         state_q           <= state_d;
         done_q            <= done_d;
         result_q          <= result_d;
         dec_dataA_q       <= dec_dataA_d;
         dec_dataB_q       <= dec_dataB_d;
         dec_clk_en_q      <= dec_clk_en_d;
         new_instruction_q <= new_instruction_d;
         reg_wr_q          <= reg_wr_d;
         reg_sel_q         <= reg_sel_d;
         reg_addr_q        <= reg_addr_d;
         reg_data_q        <= reg_data_d;
      end
   end

   assign bus.done            = done_q;
   assign bus.result          = result_q;
   assign bus.dec_dataA       = dec_dataA_q;
   assign bus.dec_dataB       = dec_dataB_q;
   assign bus.dec_clk_en      = dec_clk_en_q;
   assign bus.new_instruction = new_instruction_q;
   assign bus.reg_wr          = reg_wr_q;
   assign bus.reg_sel         = reg_sel_q;
   assign bus.reg_addr        = reg_addr_q;
   assign bus.reg_data        = reg_data_q;
   assign bus.fifo_count      = count_q;
endmodule

// File: tb/tb_video_instruction_sequencer.sv
// Directed bench for video_instruction_sequencer with a scoreboard of expected
// custom-instruction results and register-bank writes.
module tb_video_instruction_sequencer;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   typedef struct packed {
      logic [1:0]  sel;
      logic [4:0]  addr;
      logic [27:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   video_instruction_sequencer_if #(.PTR_W(PTR_W)) bus ();

   video_instruction_sequencer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   wr_total = 0;
   wr_t  wr_exp[$];
   logic res_exp[$];
   int   acc_cyc[$];
   wr_t  mon_e;
   logic mon_r;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // decoder model: latches fields from the presented words on dec_clk_en
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.opcode <= '0;
         bus.R1     <= '0;
         bus.data   <= '0;
      end else if (bus.dec_clk_en) begin
         bus.opcode <= bus.dec_dataA[1:0];
         bus.R1     <= bus.dec_dataA[8:4];
         bus.data   <= bus.dec_dataB[27:0];
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.done) begin
            if (res_exp.size() == 0) chk("done_without_expectation", bus.done, 1'b0);
            else begin
               mon_r = res_exp.pop_front();
               chk("done_result", bus.result, {63'b0, mon_r});
            end
         end
         if (bus.reg_wr) begin
            if (wr_exp.size() == 0) chk("write_without_expectation", bus.reg_wr, 1'b0);
            else begin
               mon_e = wr_exp[0];
               chk("reg_sel", bus.reg_sel, mon_e.sel);
               chk("reg_addr", bus.reg_addr, mon_e.addr);
               chk("reg_data", bus.reg_data, mon_e.data);
               if (bus.bank_ready) begin
                  void'(wr_exp.pop_front());
                  acc_cyc.push_back(cyc);
                  wr_total++;
               end
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic rej);
      bus.start = 1'b1;
      bus.dataA = a;
      bus.dataB = b;
      res_exp.push_back(rej);
      if (!rej && a[1:0] != 2'b11) wr_exp.push_back(wr_t'({a[1:0], a[8:4], b[27:0]}));
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (wr_exp.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk({tag, "_timeout"}, wr_exp.size(), 0);
      repeat (2) @(negedge clk);
      chk({tag, "_count_empty"}, bus.fifo_count, 0);
      chk({tag, "_reg_wr_idle"}, bus.reg_wr, 0);
      chk({tag, "_new_instr_idle"}, bus.new_instruction, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int base;
      bus.start      = 1'b0;
      bus.dataA      = '0;
      bus.dataB      = '0;
      bus.bank_ready = 1'b0;

      // reset values
      @(negedge clk);
      chk("rst_done", bus.done, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_dec_dataA", bus.dec_dataA, 0);
      chk("rst_dec_dataB", bus.dec_dataB, 0);
      chk("rst_dec_clk_en", bus.dec_clk_en, 0);
      chk("rst_new_instr", bus.new_instruction, 1);
      chk("rst_reg_wr", bus.reg_wr, 0);
      chk("rst_reg_fields", {bus.reg_sel, bus.reg_addr, bus.reg_data}, 0);
      chk("rst_fifo_count", bus.fifo_count, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // single instruction latency
      bus.bank_ready = 1'b1;
      issue(32'h0000_0051, 32'h0012_3456, 1'b0);
      @(negedge clk);
      chk("t1_done", bus.done, 1);
      chk("t1_count", bus.fifo_count, 1);
      chk("t1_clk_en", bus.dec_clk_en, 0);
      @(negedge clk);
      chk("t2_new_instr", bus.new_instruction, 0);
      chk("t2_dec_dataA", bus.dec_dataA, 32'h0000_0051);
      chk("t2_dec_dataB", bus.dec_dataB, 32'h0012_3456);
      @(negedge clk);
      chk("t3_clk_en", bus.dec_clk_en, 1);
      chk("t3_new_instr", bus.new_instruction, 0);
      @(negedge clk);
      chk("t4_clk_en", bus.dec_clk_en, 0);
      chk("t4_new_instr", bus.new_instruction, 1);
      chk("t4_reg_wr", bus.reg_wr, 0);
      @(negedge clk);
      chk("t5_reg_wr", bus.reg_wr, 1);
      chk("t5_fields", {bus.reg_sel, bus.reg_addr, bus.reg_data}, {2'b01, 5'd5, 28'h0123456});
      chk("t5_dec_dataA_hold", bus.dec_dataA, 32'h0000_0051);
      @(negedge clk);
      chk("t6_reg_wr", bus.reg_wr, 0);
      @(posedge clk); #1;

      // five back-to-back starts while the bank is stalled
      bus.bank_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) chk("stall_full_count", bus.fifo_count, DEPTH);
         issue(((32'(i) + 32'd10) << 4) | 32'(i % 3), 32'h0A00_0000 + 32'(i), i == 4);
      end
      repeat (6) @(negedge clk);
      chk("stall_reg_wr_held", bus.reg_wr, 1);
      chk("stall_count", bus.fifo_count, 3);
      @(posedge clk); #1;

      // release the bank: four writes, five cycles apart
      acc_cyc.delete();
      bus.bank_ready = 1'b1;
      drain("release");
      chk("release_writes", acc_cyc.size(), 4);
      for (int k = 1; k < acc_cyc.size(); k++) chk("release_spacing", acc_cyc[k] - acc_cyc[k-1], 5);

      // reserved opcode is discarded, next instruction written four cycles later
      issue(32'h0000_0073, 32'h0000_DEAD, 1'b0);
      issue(32'h0000_00C0, 32'h00BE_EF12, 1'b0);
      for (int i = 2; i <= 9; i++) begin
         @(negedge clk);
         chk("op3_reg_wr_timing", bus.reg_wr, i == 9);
      end
      @(posedge clk); #1;
      drain("op3");

      // push coinciding with CAPTURE, then fill through pointer wrap
      issue(32'h0000_0111, 32'h0111_1111, 1'b0);
      issue(32'h0000_0122, 32'h0222_2222, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pp_count_before", bus.fifo_count, 2);
      issue(32'h0000_0130, 32'h0333_3333, 1'b0);
      chk("pp_count_after", bus.fifo_count, 2);
      issue(32'h0000_0141, 32'h0444_4444, 1'b0);
      issue(32'h0000_0152, 32'h0555_5555, 1'b0);
      chk("pp_count_full", bus.fifo_count, DEPTH);
      drain("pp");

      // reset while WRITE is stalled with three queued
      bus.bank_ready = 1'b0;
      for (int i = 0; i < 4; i++) issue(32'h0000_0201 + (32'(i) << 4), 32'h0600_0000 + 32'(i), 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("prerst_reg_wr", bus.reg_wr, 1);
      chk("prerst_count", bus.fifo_count, 3);
      #1 reset = 1'b1;
      #1;
      chk("midrst_reg_wr", bus.reg_wr, 0);
      chk("midrst_count", bus.fifo_count, 0);
      chk("midrst_new_instr", bus.new_instruction, 1);
      chk("midrst_reg_fields", {bus.reg_sel, bus.reg_addr, bus.reg_data}, 0);
      wr_exp.delete();
      res_exp.delete();
      base = wr_total;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.bank_ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("postrst_no_writes", wr_total, base);
      chk("postrst_count", bus.fifo_count, 0);

      chk("leftover_writes", wr_exp.size(), 0);
      chk("leftover_results", res_exp.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/video_instruction_sequencer.md
# video_instruction_sequencer

Sits between the Nios II custom-instruction interface and the instruction decoder of the video processor. It buffers incoming instructions (dataA/dataB pairs) in a small FIFO and answers each `start` with a one-cycle `done`. It then feeds the queued instructions one at a time to the decoder, strobing its `clk_en` and gating it with `new_instruction`. It commits each decoded result to the register bank when the bank is free.

## Interface
Parameters:
- `DEPTH`, 4: instruction FIFO depth; must be a power of two, ≥2.
- `PTR_W`, 2: log2(DEPTH).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  custom-instruction start; a one-cycle pulse per instruction.
- `dataA`  in  32  instruction word A (opcode in [1:0], R1 in [8:4]).
- `dataB`  in  32  instruction word B (payload in [27:0]).
- `done`  out  1  one-cycle acknowledge for each `start`.
- `result`  out  32  custom-instruction result, valid with `done`: 0 = accepted, 1 = rejected (FIFO full).
- `dec_dataA`  out  32  word A presented to decoder.
- `dec_dataB`  out  32  word B presented to decoder.
- `dec_clk_en`  out  1  decoder latch strobe; a one-cycle pulse.
- `new_instruction`  out  1  0 = decoder may latch; 1 = previous instruction still in execution.
- `opcode`  in  2  decoded opcode from decoder.
- `R1`  in  5  decoded register index.
- `data`  in  28  decoded payload.
- `bank_ready`  in  1  register bank can accept a write this cycle.
- `reg_wr`  out  1  register-bank write enable.
- `reg_sel`  out  2  write type (00 sprite position, 01 background, 10 sprite offset).
- `reg_addr`  out  5  register index.
- `reg_data`  out  28  write data.
- `fifo_count`  out  PTR_W+1  number of queued instructions.

## Operation
- Reset values: `done`=0, `result`=0, `dec_dataA`=`dec_dataB`=0, `dec_clk_en`=0, `new_instruction`=1, `reg_wr`=0, `reg_sel`/`reg_addr`/`reg_data`=0, `fifo_count`=0. FIFO pointers clear and the FSM goes to IDLE.
- Push: when `start`=1 and the FIFO is not full, store {dataA,dataB} at the write pointer. The next cycle gives `done`=1 with `result`=0.
- If the FIFO is full, the instruction is dropped and the next cycle gives `done`=1 with `result`=1.
- A push and a pop in the same cycle are both honoured and `fifo_count` is unchanged.
- A push to a full FIFO in the same cycle as a pop is still rejected, because fullness is evaluated before the pop.
- Pointers wrap modulo DEPTH. Full when `fifo_count`==DEPTH; empty when 0.
- FSM states:
  - IDLE: `new_instruction`=1. If `fifo_count`>0, go to LOAD.
  - LOAD: drive `dec_dataA`/`dec_dataB` from the FIFO head, `new_instruction`=0. Go to STROBE.
  - STROBE: `dec_clk_en`=1 for exactly this cycle, head data held, `new_instruction`=0. Go to CAPTURE.
  - CAPTURE: `new_instruction`=1, pop the FIFO head. Opcode 11 (reserved): discard and return to IDLE. Otherwise latch `opcode`/`R1`/`data` into `reg_sel`/`reg_addr`/`reg_data` and go to WRITE.
  - WRITE: `reg_wr`=1 while in this state. Exit to IDLE on the first cycle where `reg_wr`=1 and `bank_ready`=1. `reg_*` are held stable until accepted.
- `dec_dataA`/`dec_dataB` hold their last values outside LOAD/STROBE.
- `new_instruction` is 0 only in LOAD and STROBE.

## Timing
- `done` is registered: asserted the cycle after `start`, for exactly one cycle. Back-to-back `start` pulses give back-to-back `done` pulses.
- Pushing into an empty FIFO with the FSM in IDLE: push at cycle t, count visible at t+1, LOAD at t+2, `dec_clk_en` at t+3, CAPTURE at t+4, earliest `reg_wr` at t+5.
- Throughput is one instruction per 5 cycles with `bank_ready` held high, or 4 cycles for opcode 11.
- A stall on `bank_ready`=0 holds WRITE indefinitely. The FIFO continues to accept pushes until full.
- Asserting `reset` at any point forces all outputs to their reset values immediately. Queued instructions are lost, and an in-flight `reg_wr` or `dec_clk_en` deasserts without completing.

## Test plan
- Reset then a single instruction with dataA=0x0000_0051 and dataB=0x0012_3456, `bank_ready`=1: expect `done`/`result`=0 at t+1, `dec_clk_en` pulse at t+3, and `reg_wr` at t+5 with `reg_sel`=01, `reg_addr`=5, `reg_data`=0x0123456.
- Five back-to-back `start` pulses with `bank_ready`=0: expect `result`=0,0,0,0 then 1, `fifo_count`=4, and `reg_wr` stuck high with the first instruction's fields held.
- From the previous state, raise `bank_ready`: expect four writes in FIFO order at 5-cycle spacing, then IDLE with `fifo_count`=0.
- Instruction with opcode 11 followed by one with opcode 00: expect no write for the first, and the second written with `reg_sel`=00.
- Push while popping (start coincides with CAPTURE) with 2 entries queued: expect `fifo_count` unchanged, the new entry accepted, and correct pointer wrap after DEPTH+1 instructions.
- Assert `reset` during WRITE with 3 instructions queued: expect `reg_wr`=0 and `fifo_count`=0 immediately, and no further writes after release.
